// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl: walks the SAD engine over NUM_CAND candidate blocks and keeps the minimum-SAD candidate.
module sad_search_ctrl #(
  parameter int NUM_CAND    = 16,
  parameter int CAND_STRIDE = 256,
  parameter int ADDR_W      = 15,
  parameter int TIMEOUT     = 1024
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  output logic              Busy,
  output logic              SAD_Go,
  input  logic              SAD_Done,
  input  logic [31:0]       SAD_Out,
  output logic [ADDR_W-1:0] Cand_Base,
  output logic [7:0]        Best_Idx,
  output logic [31:0]       Best_SAD,
  output logic              Done,
  output logic              Timeout_Err
);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  localparam logic [7:0] LAST = 8'(NUM_CAND - 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, UPDATE, FINISH} state_t;
  state_t state, state_n;
  logic [7:0] cand_idx, idx_n;
  logic [WD_W-1:0] wdog;
  logic [31:0] sad_lat;
  logic busy_n, sad_go_n, done_n;
  logic [ADDR_W-1:0] base_n;
  logic to_hit;
  assign to_hit = wdog == WD_MAX;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      cand_idx    <= '0;
      wdog        <= '0;
      sad_lat     <= '0;
      Busy        <= 1'b0;
      SAD_Go      <= 1'b0;
      Cand_Base   <= '0;
      Best_Idx    <= '0;
      Best_SAD    <= '1;
      Done        <= 1'b0;
      Timeout_Err <= 1'b0;
    end else begin
      state     <= state_n;
      cand_idx  <= idx_n;
      Busy      <= busy_n;
      SAD_Go    <= sad_go_n;
      Done      <= done_n;
      Cand_Base <= base_n;
      wdog      <= state == WAIT ? wdog + 1'b1 : '0;
      if (state == WAIT && SAD_Done) sad_lat <= SAD_Out;
      if (state == IDLE && Start) begin
        Best_SAD    <= '1;
        Best_Idx    <= '0;
        Timeout_Err <= 1'b0;
      end
      if (state == WAIT && !SAD_Done && to_hit) Timeout_Err <= 1'b1;
      if (state == UPDATE && sad_lat < Best_SAD) begin
        Best_SAD <= sad_lat;
        Best_Idx <= cand_idx;
      end
    end
  end
  always_comb begin
    state_n = state;
    idx_n   = cand_idx;
    unique case (state)
      IDLE: if (Start) begin
        state_n = LAUNCH;
        idx_n   = '0;
      end
      LAUNCH: state_n = WAIT;
      WAIT:   state_n = SAD_Done ? UPDATE : to_hit ? FINISH : WAIT;
      UPDATE: if (cand_idx == LAST) state_n = FINISH;
      else begin
        state_n = LAUNCH;
        idx_n   = cand_idx + 8'd1;
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they belong to
  always_comb begin
    busy_n   = state_n != IDLE;
    sad_go_n = state_n == LAUNCH;
    done_n   = state_n == FINISH;
    base_n   = sad_go_n ? ADDR_W'(32'(idx_n) * CAND_STRIDE) : Cand_Base;
  end
endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb_sad_search_ctrl: table-driven and randomized checks of sad_search_ctrl against a behavioural engine and run model.
module tb_sad_search_ctrl;
  localparam int NC = 4;
  localparam int TO = 16;
  logic Clk = 1'b0, Rst = 1'b1, Start = 1'b0;
  logic spur_done = 1'b0, eng_done = 1'b0;
  logic [31:0] spur_out = '0, eng_out = '0;
  logic SAD_Done;
  logic [31:0] SAD_Out;
  logic Busy, SAD_Go, Done, Timeout_Err;
  logic [14:0] Cand_Base;
  logic [7:0] Best_Idx;
  logic [31:0] Best_SAD;
  int checks = 0, errors = 0, go_n = 0, ek;
  int cur_lat[NC];
  logic [31:0] cur_sad[NC];
  typedef struct packed {
    logic [3:0][7:0]  lat;
    logic [3:0][31:0] sad;
    logic [7:0]       e_cyc;
    logic [7:0]       e_idx;
    logic [31:0]      e_sad;
    logic             e_err;
    logic [7:0]       rs;
    logic [7:0]       sp;
  } vec_t;
  vec_t vecs[9];
  assign SAD_Done = eng_done | spur_done;
  assign SAD_Out  = spur_done ? spur_out : eng_out;
  sad_search_ctrl #(.NUM_CAND(NC), .CAND_STRIDE(256), .ADDR_W(15), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Busy(Busy), .SAD_Go(SAD_Go),
    .SAD_Done(SAD_Done), .SAD_Out(SAD_Out), .Cand_Base(Cand_Base),
    .Best_Idx(Best_Idx), .Best_SAD(Best_SAD), .Done(Done), .Timeout_Err(Timeout_Err)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // engine model: answers the k-th Go with SAD_Done in its lat-th wait cycle; lat 0 never answers
  initial forever begin
    @(negedge Clk);
    if (SAD_Go === 1'b1) begin
      ek = go_n % NC;
      chk("cand_base", 32'(Cand_Base), 32'((go_n * 256) % 32768));
      go_n++;
      @(negedge Clk);
      chk("go_one_cycle", 32'(SAD_Go), 32'd0);
      if (cur_lat[ek] > 0) begin
        repeat (cur_lat[ek] - 1) @(negedge Clk);
        eng_done = 1'b1;
        eng_out  = cur_sad[ek];
        @(negedge Clk);
        eng_done = 1'b0;
      end
    end
  end
  function automatic vec_t mk(input int l0, l1, l2, l3, input logic [31:0] s0, s1, s2, s3,
                              input int cyc, idx, input logic [31:0] es, input logic er, input int rs, sp);
    vec_t v;
    v.lat[0] = 8'(l0); v.lat[1] = 8'(l1); v.lat[2] = 8'(l2); v.lat[3] = 8'(l3);
    v.sad[0] = s0; v.sad[1] = s1; v.sad[2] = s2; v.sad[3] = s3;
    v.e_cyc = 8'(cyc); v.e_idx = 8'(idx); v.e_sad = es; v.e_err = er;
    v.rs = 8'(rs); v.sp = 8'(sp);
    return v;
  endfunction
  // reference: scan candidates in order, strict-less keeps the earliest minimum, stop at the first silent engine
  function automatic void model(output int cyc, output logic [7:0] bi, output logic [31:0] bs, output logic er);
    cyc = 1; bi = '0; bs = '1; er = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (cur_lat[i] == 0 || cur_lat[i] > TO) begin
        cyc += 1 + TO;
        er = 1'b1;
        break;
      end
      cyc += cur_lat[i] + 2;
      if (cur_sad[i] < bs) begin
        bs = cur_sad[i];
        bi = 8'(i);
      end
    end
  endfunction
  task automatic run(input int e_cyc, input logic [7:0] e_idx, input logic [31:0] e_sad,
                     input logic e_err, input int rs_at, input int sp_at, input string tag);
    int first, dones;
    first = 0; dones = 0; go_n = 0;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int c = 1; c <= e_cyc + 25; c++) begin
      if (Done === 1'b1) begin
        dones++;
        if (first == 0) first = c;
      end
      Start     = (c == rs_at);
      spur_done = (c == sp_at);
      spur_out  = 32'd1;
      @(negedge Clk);
    end
    Start = 1'b0;
    spur_done = 1'b0;
    chk({tag, " done_cycle"}, first, e_cyc);
    chk({tag, " done_count"}, dones, 1);
    chk({tag, " best_idx"}, 32'(Best_Idx), 32'(e_idx));
    chk({tag, " best_sad"}, Best_SAD, e_sad);
    chk({tag, " timeout_err"}, 32'(Timeout_Err), 32'(e_err));
    chk({tag, " busy_after"}, 32'(Busy), 32'd0);
  endtask
  initial begin
    int cyc, w;
    logic [7:0] bi;
    logic [31:0] bs;
    logic er, seen_busy, seen_go, seen_done;
    for (int j = 0; j < NC; j++) begin
      cur_lat[j] = 3;
      cur_sad[j] = 32'd5 + 32'(j);
    end
    repeat (3) @(negedge Clk);
    chk("rst busy", 32'(Busy), 32'd0);
    chk("rst go", 32'(SAD_Go), 32'd0);
    chk("rst base", 32'(Cand_Base), 32'd0);
    chk("rst idx", 32'(Best_Idx), 32'd0);
    chk("rst sad", Best_SAD, 32'hFFFFFFFF);
    chk("rst done", 32'(Done), 32'd0);
    chk("rst err", 32'(Timeout_Err), 32'd0);
    Rst = 1'b0;
    seen_busy = 0; seen_go = 0; seen_done = 0;
    repeat (20) begin
      @(negedge Clk);
      seen_busy |= Busy; seen_go |= SAD_Go; seen_done |= Done;
    end
    chk("idle busy", 32'(seen_busy), 32'd0);
    chk("idle go", 32'(seen_go), 32'd0);
    chk("idle done", 32'(seen_done), 32'd0);
    chk("idle sad", Best_SAD, 32'hFFFFFFFF);
    // reset pulse while waiting on candidate 1; the engine's later answer must be ignored
    go_n = 0;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    w = 0;
    while (go_n < 2 && w < 40) begin
      @(negedge Clk);
      w++;
    end
    chk("midrun reach cand1", 32'(go_n >= 2), 32'd1);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("midrst busy", 32'(Busy), 32'd0);
    chk("midrst go", 32'(SAD_Go), 32'd0);
    chk("midrst base", 32'(Cand_Base), 32'd0);
    chk("midrst idx", 32'(Best_Idx), 32'd0);
    chk("midrst sad", Best_SAD, 32'hFFFFFFFF);
    chk("midrst done", 32'(Done), 32'd0);
    seen_busy = 0; seen_go = 0; seen_done = 0;
    repeat (15) begin
      @(negedge Clk);
      seen_busy |= Busy; seen_go |= SAD_Go; seen_done |= Done;
    end
    chk("postrst busy", 32'(seen_busy), 32'd0);
    chk("postrst go", 32'(seen_go), 32'd0);
    chk("postrst done", 32'(seen_done), 32'd0);
    chk("postrst sad", Best_SAD, 32'hFFFFFFFF);
    vecs[0] = mk(3, 3, 3, 3, 500, 200, 300, 200, 21, 1, 200, 0, 0, 0);
    vecs[1] = mk(1, 2, 5, 4, '1, '1, '1, '1, 21, 0, '1, 0, 0, 0);
    vecs[2] = mk(3, 3, 0, 3, 100, 50, 7, 1, 28, 1, 50, 1, 0, 0);
    vecs[3] = mk(16, 1, 1, 1, 10, 10, 9, 9, 28, 2, 9, 0, 0, 0);
    vecs[4] = mk(17, 1, 1, 1, 5, 5, 5, 5, 18, 0, '1, 1, 0, 0);
    vecs[5] = mk(2, 2, 2, 2, 0, 0, 5, 0, 17, 0, 0, 0, 0, 0);
    vecs[6] = mk(1, 1, 1, 1, 40, 30, 20, 10, 13, 3, 10, 0, 5, 0);
    vecs[7] = mk(2, 2, 2, 2, 9, 9, 9, 9, 17, 0, 9, 0, 0, 1);
    vecs[8] = mk(1, 1, 1, 18, 7, 3, 8, 2, 27, 1, 3, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < NC; j++) begin
        cur_lat[j] = int'(vecs[i].lat[j]);
        cur_sad[j] = vecs[i].sad[j];
      end
      run(int'(vecs[i].e_cyc), vecs[i].e_idx, vecs[i].e_sad, vecs[i].e_err,
          int'(vecs[i].rs), int'(vecs[i].sp), $sformatf("vec%0d", i));
    end
    spur_out = 32'd0;
    spur_done = 1'b1;
    @(negedge Clk);
    spur_done = 1'b0;
    repeat (3) @(negedge Clk);
    chk("idle spur busy", 32'(Busy), 32'd0);
    chk("idle spur sad", Best_SAD, 32'd3);
    chk("idle spur idx", 32'(Best_Idx), 32'd1);
    for (int r = 0; r < 30; r++) begin
      for (int j = 0; j < NC; j++) begin
        cur_lat[j] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 18));
        cur_sad[j] = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(0, 6));
      end
      model(cyc, bi, bs, er);
      run(cyc, bi, bs, er, ($urandom_range(0, 1) == 1) ? 3 : 0, 0, $sformatf("rnd%0d", r));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
